// File: rtl/lemmings_array.sv
// NUM_LEM independent walk/fall/dig lemmings with fatal-fall detection and a
// live-population count. One lane instance per lemming.

module lemmings_lane #(
   parameter int FALL_MAX = 20
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic ground_i,
   input  logic dig_i,
   input  logic bump_left_i,
   input  logic bump_right_i,
   output logic walk_left_o,
   output logic walk_right_o,
   output logic aaah_o,
   output logic digging_o,
   output logic alive_o
);
   localparam int CW = $clog2(FALL_MAX + 2);

   typedef enum logic [2:0] {
      WALK_L, WALK_R, FALL_L, FALL_R, DIG_L, DIG_R, SPLAT
   } st_e;

   st_e           state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [4:0]    out_q;

   // {alive, digging, aaah, walk_right, walk_left}
   function automatic logic [4:0] decode(input st_e s);
      case (s)
         WALK_L:        decode = 5'b10001;
         WALK_R:        decode = 5'b10010;
         FALL_L,FALL_R: decode = 5'b10100;
         DIG_L, DIG_R:  decode = 5'b11000;
         default:       decode = 5'b00000;
      endcase
   endfunction

   always_comb begin
      state_d = state_q;
      cnt_d   = '0;
      case (state_q)
         WALK_L: begin
            if (!ground_i)        state_d = FALL_L;
            else if (dig_i)       state_d = DIG_L;
            else if (bump_left_i) state_d = WALK_R;
         end
         WALK_R: begin
            if (!ground_i)         state_d = FALL_R;
            else if (dig_i)        state_d = DIG_R;
            else if (bump_right_i) state_d = WALK_L;
         end
         DIG_L: if (!ground_i) state_d = FALL_L;
         DIG_R: if (!ground_i) state_d = FALL_R;
         FALL_L, FALL_R: begin
            // Counter saturates so very long falls can never wrap into survival.
            if (!ground_i)
               cnt_d = (cnt_q == CW'(FALL_MAX)) ? cnt_q : cnt_q + 1'b1;
            else if (cnt_q == CW'(FALL_MAX))
               state_d = SPLAT;
            else
               state_d = (state_q == FALL_L) ? WALK_L : WALK_R;
         end
         default: state_d = SPLAT;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= WALK_L;
         cnt_q   <= '0;
         out_q   <= 5'b10001;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         out_q   <= decode(state_d);
      end
   end

   assign {alive_o, digging_o, aaah_o, walk_right_o, walk_left_o} = out_q;
endmodule

module lemmings_array #(
   parameter int NUM_LEM  = 4,
   parameter int FALL_MAX = 20
) (
   input  logic                         sys_clk,
   input  logic                         sys_rst_n,
   input  logic [NUM_LEM-1:0]           bump_left,
   input  logic [NUM_LEM-1:0]           bump_right,
   input  logic [NUM_LEM-1:0]           ground,
   input  logic [NUM_LEM-1:0]           dig,
   output logic [NUM_LEM-1:0]           walk_left,
   output logic [NUM_LEM-1:0]           walk_right,
   output logic [NUM_LEM-1:0]           aaah,
   output logic [NUM_LEM-1:0]           digging,
   output logic [$clog2(NUM_LEM+1)-1:0] alive_cnt
);
   localparam int AW = $clog2(NUM_LEM + 1);

   logic [NUM_LEM-1:0] alive;

   for (genvar i = 0; i < NUM_LEM; i++) begin : g_lane
      lemmings_lane #(.FALL_MAX(FALL_MAX)) u_lane (
         .clk_i        (sys_clk),
         .rst_ni       (sys_rst_n),
         .ground_i     (ground[i]),
         .dig_i        (dig[i]),
         .bump_left_i  (bump_left[i]),
         .bump_right_i (bump_right[i]),
         .walk_left_o  (walk_left[i]),
         .walk_right_o (walk_right[i]),
         .aaah_o       (aaah[i]),
         .digging_o    (digging[i]),
         .alive_o      (alive[i])
      );
   end

   always_comb begin
      alive_cnt = '0;
      for (int i = 0; i < NUM_LEM; i++)
         alive_cnt = alive_cnt + AW'(alive[i]);
   end
endmodule

// File: tb/tb_lemmings_array.sv
// Randomized and directed bench for lemmings_array, checked every cycle
// against a mode/direction/fall-length model of each lemming.

module tb_lemmings_array;
   localparam int NL = 4;
   localparam int FM = 20;
   localparam int AW = $clog2(NL + 1);

   localparam int M_WALK = 0, M_FALL = 1, M_DIG = 2, M_DEAD = 3;

   logic          sys_clk = 1'b0;
   logic          sys_rst_n;
   logic [NL-1:0] bump_left, bump_right, ground, dig;
   logic [NL-1:0] walk_left, walk_right, aaah, digging;
   logic [AW-1:0] alive_cnt;

   int total = 0;
   int bad   = 0;

   int mode [NL];
   bit dir_r[NL];
   int flen [NL];

   lemmings_array #(.NUM_LEM(NL), .FALL_MAX(FM)) dut (
      .sys_clk    (sys_clk),
      .sys_rst_n  (sys_rst_n),
      .bump_left  (bump_left),
      .bump_right (bump_right),
      .ground     (ground),
      .dig        (dig),
      .walk_left  (walk_left),
      .walk_right (walk_right),
      .aaah       (aaah),
      .digging    (digging),
      .alive_cnt  (alive_cnt)
   );

   always #5 sys_clk = ~sys_clk;

   task automatic chk(input string tag, input int got, input int exp);
      total++;
      if (got != exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < NL; i++) begin
         mode[i] = M_WALK; dir_r[i] = 1'b0; flen[i] = 0;
      end
   endtask

   task automatic model_edge();
      if (!sys_rst_n) begin
         model_reset();
         return;
      end
      for (int i = 0; i < NL; i++) begin
         case (mode[i])
            M_WALK: begin
               if (!ground[i]) begin mode[i] = M_FALL; flen[i] = 1; end
               else if (dig[i]) mode[i] = M_DIG;
               else if (dir_r[i] ? bump_right[i] : bump_left[i]) dir_r[i] = !dir_r[i];
            end
            M_DIG: if (!ground[i]) begin mode[i] = M_FALL; flen[i] = 1; end
            M_FALL: begin
               if (!ground[i]) flen[i]++;
               else if (flen[i] > FM) mode[i] = M_DEAD;
               else mode[i] = M_WALK;
            end
            default: ;
         endcase
      end
   endtask

   task automatic check_all(input string tag);
      logic [NL-1:0] ewl, ewr, ea, ed;
      int alive_n;
      ewl = '0; ewr = '0; ea = '0; ed = '0; alive_n = 0;
      for (int i = 0; i < NL; i++) begin
         ewl[i] = (mode[i] == M_WALK) && !dir_r[i];
         ewr[i] = (mode[i] == M_WALK) &&  dir_r[i];
         ea[i]  = (mode[i] == M_FALL);
         ed[i]  = (mode[i] == M_DIG);
         if (mode[i] != M_DEAD) alive_n++;
      end
      chk({tag, ".walk_left"},  int'(walk_left),  int'(ewl));
      chk({tag, ".walk_right"}, int'(walk_right), int'(ewr));
      chk({tag, ".aaah"},       int'(aaah),       int'(ea));
      chk({tag, ".digging"},    int'(digging),    int'(ed));
      chk({tag, ".alive_cnt"},  int'(alive_cnt),  alive_n);
   endtask

   task automatic step(input string tag);
      @(posedge sys_clk);
      model_edge();
      #1;
      check_all(tag);
   endtask

   task automatic quiet();
      ground = '1; dig = '0; bump_left = '0; bump_right = '0;
   endtask

   // Drops ground on channel ch for n edges, then restores it; returns aaah cycles seen.
   task automatic fall_run(input int ch, input int n, output int hi);
      hi = 0;
      ground[ch] = 1'b0;
      repeat (n) begin step("fall"); if (aaah[ch]) hi++; end
      ground[ch] = 1'b1;
      step("land");
      if (aaah[ch]) hi++;
   endtask

   initial begin
      int hi;
      int glow[NL];
      sys_rst_n = 1'b0;
      model_reset();
      for (int i = 0; i < NL; i++) glow[i] = 0;

      // Reset held with random inputs
      repeat (5) begin
         {bump_left, bump_right, ground, dig} = 16'($urandom);
         step("rst_hold");
      end
      quiet();
      sys_rst_n = 1'b1;
      repeat (10) begin
         step("rst_rel");
         chk("rst_rel.wl_all", int'(walk_left), 'hf);
         chk("rst_rel.alive4", int'(alive_cnt), NL);
      end

      // Bump priority on channel 0
      bump_left[0] = 1'b1; step("bump_l");
      chk("bump_l.wr0", int'(walk_right[0]), 1);
      bump_right[0] = 1'b1; step("bump_both");
      chk("bump_both.wl0", int'(walk_left[0]), 1);
      quiet();
      ground[0] = 1'b0; dig[0] = 1'b1; bump_left[0] = 1'b1; step("fall_prio");
      chk("fall_prio.aaah0", int'(aaah[0]), 1);
      chk("fall_prio.dig0",  int'(digging[0]), 0);
      quiet(); step("fall_prio_land");
      chk("fall_prio_land.wl0", int'(walk_left[0]), 1);

      // Survivable fall of exactly FM cycles on channel 1 heading right
      bump_left[1] = 1'b1; step("c1_turn"); quiet();
      fall_run(1, FM, hi);
      chk("survive.aaah_len", hi, FM);
      chk("survive.wr1", int'(walk_right[1]), 1);
      chk("survive.alive", int'(alive_cnt), NL);

      // Fatal fall of FM+1 cycles on channel 2
      fall_run(2, FM + 1, hi);
      chk("splat.aaah_len", hi, FM + 1);
      chk("splat.alive", int'(alive_cnt), NL - 1);
      for (int k = 0; k < 8; k++) begin
         bump_left[2] = k[0]; dig[2] = k[1]; ground[2] = k[2];
         step("splat_hold");
         chk("splat_hold.outs", int'({walk_left[2], walk_right[2], aaah[2], digging[2]}), 0);
      end
      quiet();

      // Dig then fall on channel 3 while other channels see noise
      dig[3] = 1'b1; step("dig3");
      chk("dig3.digging", int'(digging[3]), 1);
      dig[3] = 1'b0;
      for (int k = 0; k < 6; k++) begin
         bump_left  = NL'($urandom);
         bump_right = NL'($urandom);
         dig[2:0]   = 3'($urandom);
         step("dig3_bumps");
         chk("dig3_bumps.digging", int'(digging[3]), 1);
      end
      quiet();
      fall_run(3, 3, hi);
      chk("dig3.fall_len", hi, 3);
      chk("dig3.wl3", int'(walk_left[3]), 1);

      // Async reset between edges with ch2 splatted and ch1 mid-fall
      dig[1] = 1'b0; ground[1] = 1'b0;
      repeat (10) step("c1_fall10");
      chk("c1_fall10.aaah1", int'(aaah[1]), 1);
      quiet();
      #2 sys_rst_n = 1'b0;
      #1;
      model_reset();
      chk("async.wl", int'(walk_left), 'hf);
      chk("async.wr", int'(walk_right), 0);
      chk("async.aaah", int'(aaah), 0);
      chk("async.dig", int'(digging), 0);
      chk("async.alive", int'(alive_cnt), NL);
      #1 sys_rst_n = 1'b1;
      step("post_async");
      fall_run(1, FM, hi);
      chk("post_async.aaah_len", hi, FM);
      chk("post_async.wl1", int'(walk_left[1]), 1);

      // Random phase with bursts of ground loss of varied length
      for (int c = 0; c < 2000; c++) begin
         for (int i = 0; i < NL; i++) begin
            if (glow[i] > 0) begin
               ground[i] = 1'b0; glow[i]--;
            end else if ($urandom_range(0, 9) == 0) begin
               ground[i] = 1'b0; glow[i] = $urandom_range(0, 24);
            end else
               ground[i] = 1'b1;
            dig[i]        = ($urandom_range(0, 7) == 0);
            bump_left[i]  = ($urandom_range(0, 3) == 0);
            bump_right[i] = ($urandom_range(0, 3) == 0);
         end
         sys_rst_n = !(c % 300 == 299);
         step("rand");
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
